fifo_rd_arbiter: RTL
====================

Name: fifo_rd_arbiter

Overview:
- Round-robin read scheduler that drains NUM_SRC independent sync FIFOs (each built on fifo_ctrl plus storage) onto a single valid/ready output stream.
- Issues per-FIFO read enables, registers the popped word and tags it with its source index.
- Grants each source a burst of up to MAX_BURST words before rotating, giving fair sharing of one downstream consumer between several queues.

Parameters:
- NUM_SRC, 4, number of FIFOs served (>=2).
- DATA_WIDTH, 8, FIFO word width.
- MAX_BURST, 4, maximum words popped per grant (>=1; 1 = per-word round robin).
- SRC_W, $clog2(NUM_SRC), derived; width of source index. Not overridden.

Ports:
- i_Clk  input  1  clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_Empty  input  NUM_SRC  per-FIFO empty flag, bit i = FIFO i.
- i_Rd_Data  input  NUM_SRC*DATA_WIDTH  per-FIFO head word; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]. Valid combinationally whenever i_Empty[i]=0.
- o_Rd_En  output  NUM_SRC  per-FIFO pop strobe, at most one bit set.
- o_Data  output  DATA_WIDTH  registered output word.
- o_Src_Id  output  SRC_W  index of the FIFO that supplied o_Data.
- o_Valid  output  1  o_Data/o_Src_Id valid.
- i_Ready  input  1  consumer accepts the word when o_Valid & i_Ready.
- o_Grant  output  NUM_SRC  registered one-hot current grant; 0 in IDLE.

Behaviour:
- Reset (synchronous, active-high; dominates all other inputs):
  - o_Valid=0, o_Data=0, o_Src_Id=0, o_Grant=0.
  - o_Rd_En=0 while i_Reset=1.
  - FSM=IDLE, rr_ptr=0, burst_cnt=0.
- Internal state: FSM {IDLE, BURST}; rr_ptr (SRC_W bits); grant index g; burst_cnt ($clog2(MAX_BURST+1) bits).
- Output register slot is loadable when (~o_Valid) | i_Ready.
- Pop condition (combinational): FSM=BURST & ~i_Empty[g] & loadable. When true, o_Rd_En[g]=1 and all other bits 0; otherwise o_Rd_En=0.
  - o_Rd_En is never asserted to an empty FIFO or during reset.
- On pop, next edge: o_Data = slice g of i_Rd_Data, o_Src_Id=g, o_Valid=1, burst_cnt+1.
- Valid clears: if o_Valid & i_Ready with no pop, o_Valid=0 at the next edge. o_Data is held (don't-care).
- Stall: o_Valid=1 & i_Ready=0 holds o_Data, o_Src_Id and o_Valid stable. No pop; burst_cnt held.
- Throughput: 1 word/cycle inside a burst with i_Ready=1. Latency: o_Rd_En to o_Valid is 1 cycle.
- IDLE:
  - If any i_Empty bit is 0, select the first non-empty index scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - Load g, set o_Grant one-hot, burst_cnt=0, go to BURST.
  - No pop occurs in IDLE, so there is a 1-cycle arbitration bubble per grant.
- BURST exits to IDLE, with rr_ptr=(g+1) mod NUM_SRC and o_Grant=0, when either:
  - a pop occurs with burst_cnt==MAX_BURST-1, or
  - i_Empty[g]=1 (source ran dry; no pop that cycle).
- BURST otherwise stays, including during stall.
- A source that is the only non-empty one is re-granted after the bubble.
- Changes on i_Empty of non-granted sources have no effect until the next IDLE.
- Reset mid-burst: the word in the output register is discarded; words already popped are lost (this is accepted). Arbitration restarts from source 0.
- Wrap-around: rr_ptr and the scan wrap modulo NUM_SRC. This also holds for non-power-of-2 NUM_SRC, where indices >= NUM_SRC are never selected.

Test Plan:
- Defaults (NUM_SRC=4, DATA_WIDTH=8, MAX_BURST=4) throughout.
- Reset: hold i_Reset 2 cycles with all FIFOs non-empty and i_Ready=1 -> o_Valid=0, o_Grant=0, o_Rd_En=0, o_Data=0 throughout.
- Single source: FIFO2 holds 0x20..0x25, i_Ready=1 -> o_Grant=4'b0100 and words 0x20..0x23 on 4 consecutive cycles with o_Src_Id=2. Then 1 bubble cycle, re-grant src2, 0x24, 0x25, then IDLE with o_Grant=0.
- Fairness: all four FIFOs hold 8 words (0xi0..0xi7) -> grant order 0,1,2,3,0,1,2,3. Each grant delivers exactly 4 in-order words; no o_Rd_En overlap.
- Backpressure: drop i_Ready for 3 cycles while o_Valid=1 mid-burst -> o_Data/o_Src_Id stable, o_Rd_En=0, burst_cnt unchanged. After release, the sequence continues with no loss or duplication.
- Dry source: FIFO1 holds 2 words, FIFO3 holds 5, others empty -> src1 2 words, exit on empty; src3 4 words; rr wraps 0,1,2 empty -> src3 1 word -> IDLE.
- Reset mid-burst: assert i_Reset after the 2nd pop from src0 -> next edge o_Valid=0, o_Grant=0. After release, arbitration restarts at src0 with the remaining FIFO contents.

Source files
------------

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst scheduler that drains several sync FIFOs onto one
// valid/ready stream, tagging each registered word with its source index.
module fifo_rd_arbiter #(
  parameter  int unsigned NUM_SRC    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MAX_BURST  = 4,
  localparam int unsigned SRC_W      = $clog2(NUM_SRC)
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset,
  input  logic [NUM_SRC-1:0]            i_Empty,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] i_Rd_Data,
  output logic [NUM_SRC-1:0]            o_Rd_En,
  output logic [DATA_WIDTH-1:0]         o_Data,
  output logic [SRC_W-1:0]              o_Src_Id,
  output logic                          o_Valid,
  input  logic                          i_Ready,
  output logic [NUM_SRC-1:0]            o_Grant
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  // one extra bit so rr_ptr + offset never overflows before the modulo fold
  localparam int unsigned IDX_W = SRC_W + 1;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SRC_W-1:0]      r_rr_ptr;
  logic [SRC_W-1:0]      w_rr_ptr_nxt;
  logic [SRC_W-1:0]      r_g;
  logic [SRC_W-1:0]      w_g_nxt;
  logic [SRC_W-1:0]      w_g_inc;
  logic [CNT_W-1:0]      r_burst_cnt;
  logic [CNT_W-1:0]      w_burst_cnt_nxt;
  logic [NUM_SRC-1:0]    r_grant;
  logic [NUM_SRC-1:0]    w_grant_nxt;
  logic [IDX_W-1:0]      w_scan_idx;
  logic [SRC_W-1:0]      w_scan_sel;
  logic                  w_scan_found;
  logic                  w_loadable;
  logic                  w_pop;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SRC_W-1:0]      r_src_id;
  logic                  r_valid;

  // Find the first non-empty source starting at rr_ptr, wrapping modulo NUM_SRC
  always_comb begin
    w_scan_found = 1'b0;
    w_scan_sel   = '0;
    w_scan_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_scan_idx = {1'b0, r_rr_ptr} + IDX_W'(k);
      if (w_scan_idx >= IDX_W'(NUM_SRC)) begin
        w_scan_idx = w_scan_idx - IDX_W'(NUM_SRC);
      end
      if (!w_scan_found && !i_Empty[w_scan_idx[SRC_W-1:0]]) begin
        w_scan_found = 1'b1;
        w_scan_sel   = w_scan_idx[SRC_W-1:0];
      end
    end
  end

  // Pop decision, head-word select and successor of the granted index
  always_comb begin
    w_g_inc    = (r_g == SRC_W'(NUM_SRC - 1)) ? '0 : r_g + SRC_W'(1);
    w_head     = i_Rd_Data[32'(r_g) * DATA_WIDTH +: DATA_WIDTH];
    w_loadable = ~r_valid | i_Ready;
    w_pop      = (r_state == ST_BURST) & ~i_Empty[r_g] & w_loadable & ~i_Reset;
    w_last     = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
    o_Rd_En    = w_pop ? (NUM_SRC'(1) << r_g) : '0;
  end

  // Arbitration next-state: grant in IDLE, count/exit in BURST
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_g_nxt         = r_g;
    w_burst_cnt_nxt = r_burst_cnt;
    w_grant_nxt     = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_scan_found) begin
          w_state_nxt     = ST_BURST;
          w_g_nxt         = w_scan_sel;
          w_grant_nxt     = NUM_SRC'(1) << w_scan_sel;
          w_burst_cnt_nxt = '0;
        end
      end
      ST_BURST: begin
        if (i_Empty[r_g]) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = w_g_inc;
          w_grant_nxt  = '0;
        end else if (w_pop) begin
          w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
          if (w_last) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = w_g_inc;
            w_grant_nxt  = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_g         <= '0;
      r_burst_cnt <= '0;
      r_grant     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_g         <= w_g_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_grant     <= w_grant_nxt;
    end
  end

  // Output slot: load on pop, drop valid when consumed without a refill
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_src_id <= '0;
    end else if (w_pop) begin
      r_valid  <= 1'b1;
      r_data   <= w_head;
      r_src_id <= r_g;
    end else if (r_valid && i_Ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_Data   = r_data;
  assign o_Src_Id = r_src_id;
  assign o_Valid  = r_valid;
  assign o_Grant  = r_grant;

endmodule
